fft_sdf_stage_ctrl: RTL

FFT_SDF_STAGE_CTRL -- requirements
Module: fft_sdf_stage_ctrl

---
 rtl/fft_sdf_stage_ctrl_if.sv | 26 ++
 rtl/fft_sdf_stage_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fft_sdf_stage_ctrl_if.sv
// Stream and control bundle between an SDF FFT stage controller and its
// neighbours: sample handshake in, delay-line/butterfly controls and output framing out.
interface fft_sdf_stage_ctrl_if #(
  parameter int TW_W = 5
);
  logic            in_valid;
  logic            in_sop;
  logic            in_ready;
  logic            shift_en;
  logic            bf_sel;
  logic [TW_W-1:0] tw_idx;
  logic            out_valid;
  logic            out_sop;
  logic            frame_done;
  logic            sop_err;

  modport master (
    output in_valid, in_sop,
    input  in_ready, shift_en, bf_sel, tw_idx, out_valid, out_sop, frame_done, sop_err
  );

  modport slave (
    input  in_valid, in_sop,
    output in_ready, shift_en, bf_sel, tw_idx, out_valid, out_sop, frame_done, sop_err
  );
endinterface

// File: rtl/fft_sdf_stage_ctrl.sv
// Control FSM for one single-delay-feedback FFT stage: fills the delay line,
// runs the butterfly half-frame, then drains either into the next frame or a flush.
module fft_sdf_stage_ctrl #(
  parameter int DEPTH = 32,
  parameter int TW_W  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_sdf_stage_ctrl_if.slave  bus
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, FILL, BFLY, FLUSH} state_t;

  localparam logic [TW_W-1:0] CNT_LAST = TW_W'(DEPTH - 1);

  state_t          state_q;
  logic [TW_W-1:0] cnt_q;
  logic            drain_pend_q;
  logic            in_ready_q;
  logic            shift_en_q;
  logic            bf_sel_q;
  logic [TW_W-1:0] tw_idx_q;
  logic            out_valid_q;
  logic            out_sop_q;
  logic            frame_done_q;
  logic            sop_err_q;

  logic            accept;
  logic            cnt_last;
  logic            cnt_zero;
  logic [TW_W-1:0] cnt_d;

  assign accept   = bus.in_valid && in_ready_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_zero = (cnt_q == '0);
  assign cnt_d    = cnt_last ? '0 : cnt_q + TW_W'(1);

  // Outputs are registered and describe the sample taken (or flush step) at the
  // preceding edge; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_pend_q <= 1'b0;
      in_ready_q   <= 1'b1;
      shift_en_q   <= 1'b0;
      bf_sel_q     <= 1'b0;
      tw_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sop_err_q    <= 1'b0;
    end else begin
      shift_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sop_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          bf_sel_q <= 1'b0;
          tw_idx_q <= '0;
          if (accept && bus.in_sop) begin
            shift_en_q <= 1'b1;
            cnt_q      <= TW_W'(1);
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            shift_en_q  <= 1'b1;
            bf_sel_q    <= 1'b0;
            tw_idx_q    <= '0;
            out_valid_q <= drain_pend_q;
            sop_err_q   <= bus.in_sop && !cnt_zero;
            cnt_q       <= cnt_d;
            // A sop-less sample right after the butterfly half means no new frame follows.
            if (drain_pend_q && cnt_zero && !bus.in_sop) begin
              in_ready_q <= 1'b0;
              state_q    <= FLUSH;
            end else if (cnt_last) begin
              frame_done_q <= drain_pend_q;
              drain_pend_q <= 1'b0;
              state_q      <= BFLY;
            end
          end else if (drain_pend_q && cnt_zero) begin
            bf_sel_q   <= 1'b0;
            tw_idx_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= FLUSH;
          end
        end
        BFLY: begin
          if (accept) begin
            shift_en_q  <= 1'b1;
            bf_sel_q    <= 1'b1;
            tw_idx_q    <= cnt_q;
            out_valid_q <= 1'b1;
            out_sop_q   <= cnt_zero;
            sop_err_q   <= bus.in_sop && !cnt_zero;
            cnt_q       <= cnt_d;
            if (cnt_last) begin
              drain_pend_q <= 1'b1;
              if (bus.in_sop) begin
                in_ready_q <= 1'b0;
                state_q    <= FLUSH;
              end else begin
                state_q    <= FILL;
              end
            end
          end
        end
        FLUSH: begin
          shift_en_q  <= 1'b1;
          bf_sel_q    <= 1'b0;
          tw_idx_q    <= '0;
          out_valid_q <= drain_pend_q;
          cnt_q       <= cnt_d;
          if (cnt_last) begin
            frame_done_q <= drain_pend_q;
            drain_pend_q <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.bf_sel     = bf_sel_q;
  assign bus.tw_idx     = tw_idx_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sop    = out_sop_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sop_err    = sop_err_q;

endmodule
